stack_evaluator: RTL
====================

STACK_EVALUATOR -- requirements
Module: stack_evaluator

Interface
REQ-001 Parameter: DEPTH, 8, operand stack entries (2..15).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 clear  input  1  synchronous clear; empties stack, returns to IDLE.
REQ-005 strobe  input  1  token valid; accepted only on a clk edge where ready=1.
REQ-006 is_op  input  1  1 = token is operator code in token[3:0]; 0 = token is 32-bit operand.
REQ-007 token  input  32  operand value, or operator code: A '+', B '-', C '*', D '/', E '='.
REQ-008 ready  output  1  block can accept a token this cycle.
REQ-009 answer  output  32  result of last '='; held until clear/reset.
REQ-010 done  output  1  answer valid.
REQ-011 error  output  1  sticky error flag.
REQ-012 depth  output  4  current number of stack entries.

Function
REQ-013 States SHALL be IDLE, DIV, DONE, ERR; ready=1 only in IDLE.
REQ-014 Operand accept in IDLE: depth<DEPTH -> push token, depth+1 next cycle, stay IDLE; depth==DEPTH -> ERR, stack unchanged.
REQ-015 '+', '-', '*' in IDLE with depth>=2: pop B (top), A (second), push A op B; depth-1; result on top next cycle; stay IDLE.
REQ-016 Arithmetic unsigned 32-bit, wraps mod 2^32; '*' keeps low 32 bits of product; '-' is A-B.
REQ-017 '/' in IDLE with depth>=2 and B!=0: enter DIV, restoring divider, one quotient bit per cycle, 32 iterations.
REQ-018 Division: ready=0 for cycles 1..32 after accept edge; truncated quotient A/B replaces A,B on top and ready=1 at cycle 33; depth-1.
REQ-019 '/' with B==0 -> ERR; stack unchanged.
REQ-020 Any operator with depth<2 (other than '=') -> ERR (underflow).
REQ-021 '=' with depth==1: answer<=top, done<=1, state DONE; '=' with depth!=1 -> ERR.
REQ-022 is_op=1 with code 0-9 or F -> ERR.
REQ-023 DONE and ERR: strobes ignored, ready=0, outputs held until clear.
REQ-024 ERR entry sets error=1, done=0, answer unchanged.
REQ-025 clear has priority over strobe in the same cycle; clear in DIV aborts division, no stack write.
REQ-026 After clear: depth=0, done=0, error=0, answer=0, state IDLE, ready=1 next cycle.
REQ-027 strobe while ready=0 SHALL have no effect (no queuing).

Reset
REQ-028 reset_n=0 SHALL immediately force state IDLE, depth=0, answer=0, done=0, error=0, ready=1, regardless of clk.
REQ-029 Reset asserted mid-division SHALL abort it; stack contents after reset are don't-care, depth=0.
REQ-030 Stack RAM contents need not be reset.

Verification
REQ-031 Operands 12, 3, op '+', op '=' -> answer=15, done=1, depth=1, ready=0.
REQ-032 7, 2, '-', 3, '*', '=' -> answer=15; 1, 2, '-', '=' -> answer=32'hFFFFFFFF.
REQ-033 100, 7, '/' -> ready low exactly cycles 1..32, top=14 at cycle 33; '=' -> answer=14.
REQ-034 5, 0, '/' -> error=1, depth=2, ready=0; clear -> error=0, depth=0, ready=1 next cycle.
REQ-035 DEPTH=8: push 9 operands -> error on 9th, depth=8; separately '+' on empty stack -> error=1.
REQ-036 reset_n pulsed low at cycle 10 of a division -> depth=0, ready=1, error=0, done=0 immediately; next 4, 4, '*', '=' -> answer=16.

Source files
------------

// File: rtl/stack_evaluator.sv
// RPN evaluator over a DEPTH-entry operand stack; push/+/-/* take one cycle, '/' takes 33 cycles (restoring divider).
// ready is high only in IDLE; strobes seen while ready is low are dropped, never queued.
module stack_evaluator #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        strobe,
    input  logic        is_op,
    input  logic [31:0] token,
    output logic        ready,
    output logic [31:0] answer,
    output logic        done,
    output logic        error,
    output logic [3:0]  depth
);

    typedef enum logic [1:0] {IDLE, DIV, DONE, ERR} state_t;

    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    state_t      state_q, state_d;
    logic [3:0]  depth_q, depth_d;
    logic [31:0] answer_q, answer_d;
    logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] stk_q [DEPTH];

    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [31:0] top, sec, alu_res;
    logic [32:0] rem_sh, trial;
    logic        q_bit;
    logic [31:0] rem_nx, quo_nx;

    always_comb begin
        top = '0;
        sec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (4'(i) == depth_q - 4'd1) top = stk_q[i];
            if (4'(i) == depth_q - 4'd2) sec = stk_q[i];
        end
    end

    always_comb begin
        case (token[3:0])
            4'hA:    alu_res = sec + top;
            4'hB:    alu_res = sec - top;
            default: alu_res = sec * top;
        endcase
    end

    // One restoring step: dividend bits shift out of quo_q as quotient bits shift in.
    always_comb begin
        rem_sh = {rem_q, quo_q[31]};
        trial  = rem_sh - {1'b0, dvs_q};
        q_bit  = ~trial[32];
        rem_nx = q_bit ? trial[31:0] : rem_sh[31:0];
        quo_nx = {quo_q[30:0], q_bit};
    end

    always_comb begin
        state_d  = state_q;
        depth_d  = depth_q;
        answer_d = answer_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        we       = 1'b0;
        wa       = depth_q;
        wd       = token;
        if (clear) begin
            state_d  = IDLE;
            depth_d  = 4'd0;
            answer_d = '0;
        end else begin
            case (state_q)
                IDLE: if (strobe) begin
                    if (!is_op) begin
                        if (depth_q < DEPTH_L) begin
                            we      = 1'b1;
                            depth_d = depth_q + 4'd1;
                        end else begin
                            state_d = ERR;
                        end
                    end else begin
                        case (token[3:0])
                            4'hA, 4'hB, 4'hC: begin
                                if (depth_q < 4'd2) begin
                                    state_d = ERR;
                                end else begin
                                    we      = 1'b1;
                                    wa      = depth_q - 4'd2;
                                    wd      = alu_res;
                                    depth_d = depth_q - 4'd1;
                                end
                            end
                            4'hD: begin
                                if (depth_q < 4'd2 || top == 32'd0) begin
                                    state_d = ERR;
                                end else begin
                                    state_d = DIV;
                                    quo_d   = sec;
                                    rem_d   = '0;
                                    dvs_d   = top;
                                    cnt_d   = 5'd0;
                                end
                            end
                            4'hE: begin
                                if (depth_q == 4'd1) begin
                                    answer_d = top;
                                    state_d  = DONE;
                                end else begin
                                    state_d = ERR;
                                end
                            end
                            default: state_d = ERR;
                        endcase
                    end
                end
                DIV: begin
                    quo_d = quo_nx;
                    rem_d = rem_nx;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        we      = 1'b1;
                        wa      = depth_q - 4'd2;
                        wd      = quo_nx;
                        depth_d = depth_q - 4'd1;
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            depth_q  <= 4'd0;
            answer_q <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= 5'd0;
        end else begin
            state_q  <= state_d;
            depth_q  <= depth_d;
            answer_q <= answer_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
        end
    end

    // Stack storage carries no reset; depth_q alone defines which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we && wa == 4'(i)) stk_q[i] <= wd;
        end
    end

    assign ready  = (state_q == IDLE);
    assign done   = (state_q == DONE);
    assign error  = (state_q == ERR);
    assign answer = answer_q;
    assign depth  = depth_q;

endmodule
